pipe_share_sched: RTL and testbench
===================================

Name: pipe_share_sched

Overview:
Shares one fixed-latency, valid-only XLS pipeline among NUM_REQ requesters. The pipeline has no stall input and a 2-stage valid chain. This block sits directly in front of the pipeline and does three things:
- round-robin arbitrates issue slots;
- tracks the requester ID of each in-flight transaction in a latency-matched shadow pipe;
- captures results into a response FIFO.

Credit accounting ensures the pipeline output, which cannot be back-pressured, always has a FIFO slot waiting.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
LATENCY, 2, cycles from pipe_input_valid to pipe_output_valid (>=1)
DATA_W, 32, pipeline result width
FIFO_DEPTH, 4, response FIFO entries; also total credit count (>= 2)

Ports:
clk  input  1  clock, all logic on posedge
rst  input  1  synchronous reset, active-low (0 = reset)
req_valid  input  NUM_REQ  per-requester issue request
req_ready  output  NUM_REQ  one-hot grant; issue occurs when req_valid[i] & req_ready[i]
pipe_rst  output  1  active-high reset to pipeline, equals ~rst (combinational)
pipe_input_valid  output  1  drives pipeline input_valid
pipe_output_valid  input  1  pipeline output_valid
pipe_out  input  DATA_W  pipeline result
resp_valid  output  1  response FIFO head valid
resp_id  output  clog2(NUM_REQ)  requester ID of head entry
resp_data  output  DATA_W  result of head entry
resp_ready  input  1  consumer pops head when resp_valid & resp_ready
credits  output  clog2(FIFO_DEPTH+1)  free credits
track_err  output  1  sticky: pipeline valid disagrees with shadow pipe

Behaviour:
- Reset (rst=0 at posedge):
  - rr_ptr=0, credits=FIFO_DEPTH, FIFO empty, shadow pipe valids cleared, track_err=0.
  - While rst=0: req_ready=0, pipe_input_valid=0, resp_valid=0.
  - resp_id/resp_data are don't-care when resp_valid=0.
- Arbiter:
  - If credits>0, grant the first requester with req_valid set, searching rr_ptr, rr_ptr+1, ... (mod NUM_REQ).
  - req_ready is combinational from req_valid, rr_ptr and credits. Exactly zero or one bit is set.
  - pipe_input_valid = |req_ready & rst.
  - On grant of k, next rr_ptr = (k+1) mod NUM_REQ. With no grant, rr_ptr holds.
- Credits:
  - Decrement on issue; increment on FIFO pop; hold if both occur in the same cycle.
  - Invariant: credits + in_flight + fifo_count == FIFO_DEPTH. Never below 0 or above FIFO_DEPTH.
  - Issue with credits=0 is impossible.
- Shadow pipe:
  - LATENCY stages of {valid, id}. Stage 0 loads {pipe_input_valid, granted id}; stages shift every cycle.
  - Only valid bits are reset; id fields are load-enabled on valid (no data reset).
- Capture:
  - When the shadow pipe's last stage is valid, write {id, pipe_out} into the FIFO that cycle.
  - If pipe_output_valid differs from the last-stage valid, set track_err=1. It holds until reset.
  - The capture write uses the shadow valid, not pipe_output_valid.
- FIFO:
  - Circular buffer, registered head; write and pop may occur in the same cycle.
  - Pop of an empty FIFO is ignored.
  - A write to a full FIFO cannot occur by construction. If it does, set track_err and drop the write.
- Latency:
  - Grant at cycle t → pipe_output_valid at t+LATENCY → resp_valid at t+LATENCY+1 (t+3 by default).
  - Back-to-back issue gives one response per cycle.
- Reset mid-operation: in-flight and buffered transactions are discarded, and the pipeline is reset through pipe_rst in the same cycle. No stale response appears after reset deasserts.
- Width: rr_ptr and resp_id are clog2(NUM_REQ) bits and wrap modulo NUM_REQ (non-power-of-2 NUM_REQ wraps explicitly).

Test Plan:
1. Single request:
   - Stimulus: req_valid=0001 for one cycle at t=10, resp_ready=1, pipe_out=42.
   - Required: req_ready=0001 at t=10; resp_valid=1, resp_id=0, resp_data=42 at t=13; credits 4→3 at t=11, back to 4 at t=14.
2. Round robin:
   - Stimulus: req_valid=1111 held for 8 cycles, resp_ready=1.
   - Required: grants 0,1,2,3,0,1,2,3; resp_id sequence 0,1,2,3,0,1,2,3 starting 3 cycles after the first grant.
3. Credit stall:
   - Stimulus: resp_ready=0, req_valid=0010 held.
   - Required: exactly 4 grants, then req_ready=0 and credits=0; FIFO holds 4 entries of id 1.
   - Then raise resp_ready for one cycle: 1 pop, credits=1, 1 new grant the following cycle.
4. Simultaneous issue and pop:
   - Stimulus: credits=1, FIFO non-empty, resp_ready=1, a request present.
   - Required: grant and pop in the same cycle, credits stays 1, no overflow, track_err=0.
5. Reset mid-flight:
   - Stimulus: after 2 grants, drive rst=0 for 1 cycle.
   - Required: pipe_rst=1 that cycle; afterwards resp_valid=0, credits=4, no responses emitted for those 2 grants.
6. Tracking error:
   - Stimulus: force pipe_output_valid=1 with the shadow pipe empty.
   - Required: track_err=1 the next cycle, held until rst=0; no FIFO write.

Source files
------------

// File: rtl/pipe_share_sched.sv
// pipe_share_sched
// Shares one fixed-latency, valid-only pipeline (no stall input) among NUM_REQ requesters.
//   - Round-robin arbiter grants at most one issue per cycle.
//   - A latency-matched shadow pipe carries the requester ID of each in-flight transaction.
//   - Pipeline results are captured into a response FIFO, tagged with that ID.
//   - Credits (one per FIFO entry) gate issue, so every result always has a free FIFO slot
//     when it leaves the pipeline.
//
// Ports:
//   clk               clock, all logic on posedge
//   rst               synchronous reset, active-low
//   req_valid         per-requester issue request
//   req_ready         one-hot grant (issue = req_valid & req_ready)
//   pipe_rst          active-high pipeline reset (~rst)
//   pipe_input_valid  pipeline input_valid
//   pipe_output_valid pipeline output_valid
//   pipe_out          pipeline result
//   resp_valid        response FIFO head valid
//   resp_id           requester ID of the head entry
//   resp_data         result of the head entry
//   resp_ready        consumer pops the head when resp_valid & resp_ready
//   credits           free credits
//   track_err         sticky: pipeline valid disagreed with shadow pipe, or FIFO overflow
module pipe_share_sched #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned LATENCY    = 2,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    localparam int unsigned IdW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int unsigned CrW       = $clog2(FIFO_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_valid,
    output logic [NUM_REQ-1:0] req_ready,
    output logic               pipe_rst,
    output logic               pipe_input_valid,
    input  logic               pipe_output_valid,
    input  logic [DATA_W-1:0]  pipe_out,
    output logic               resp_valid,
    output logic [IdW-1:0]     resp_id,
    output logic [DATA_W-1:0]  resp_data,
    input  logic               resp_ready,
    output logic [CrW-1:0]     credits,
    output logic               track_err
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned IdW1 = IdW + 1;

    localparam logic [IdW:0]    NumReqW = IdW1'(NUM_REQ);
    localparam logic [IdW-1:0]  LastId  = IdW'(NUM_REQ - 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(FIFO_DEPTH - 1);
    localparam logic [CrW-1:0]  DepthCr = CrW'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [IdW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CrW-1:0]    credits_q, credits_d;
    logic              track_err_q, track_err_d;

    logic [LATENCY-1:0] sh_valid_q;
    logic [IdW-1:0]     sh_id_q [LATENCY];

    logic [DATA_W-1:0] mem_data_q [FIFO_DEPTH];
    logic [IdW-1:0]    mem_id_q   [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CrW-1:0]    count_q, count_d;

    // ------------------------------------------------------------------
    // Round-robin arbiter
    // ------------------------------------------------------------------
    logic [NUM_REQ-1:0] grant;
    logic [IdW-1:0]     grant_id;
    logic               grant_any;
    logic [IdW:0]       cand;

    always_comb begin
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        cand      = '0;
        if (rst && (credits_q != '0)) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                // Explicit wrap so non-power-of-2 NUM_REQ never indexes past the last requester.
                cand = {1'b0, rr_ptr_q} + IdW1'(i);
                if (cand >= NumReqW) begin
                    cand = cand - NumReqW;
                end
                if (!grant_any && req_valid[cand[IdW-1:0]]) begin
                    grant_any = 1'b1;
                    grant_id  = cand[IdW-1:0];
                end
            end
            if (grant_any) begin
                grant[grant_id] = 1'b1;
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_any) begin
            rr_ptr_d = (grant_id == LastId) ? '0 : grant_id + 1'b1;
        end
    end

    logic issue;
    logic pop;

    assign req_ready        = grant;
    assign pipe_input_valid = grant_any;
    assign issue            = grant_any;
    assign pipe_rst         = ~rst;

    // ------------------------------------------------------------------
    // Shadow pipe: valid bits reset, ID fields only load behind a valid
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            sh_valid_q <= '0;
        end else begin
            sh_valid_q[0] <= issue;
            for (int unsigned s = 1; s < LATENCY; s++) begin
                sh_valid_q[s] <= sh_valid_q[s-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (issue) begin
            sh_id_q[0] <= grant_id;
        end
        for (int unsigned s = 1; s < LATENCY; s++) begin
            if (sh_valid_q[s-1]) begin
                sh_id_q[s] <= sh_id_q[s-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Capture and response FIFO
    // ------------------------------------------------------------------
    logic           cap_valid;
    logic [IdW-1:0] cap_id;
    logic           fifo_full;
    logic           fifo_empty;
    logic           fifo_wr;
    logic           overflow;

    // Capture is driven by the shadow valid; pipe_output_valid is only cross-checked.
    assign cap_valid  = sh_valid_q[LATENCY-1];
    assign cap_id     = sh_id_q[LATENCY-1];
    assign fifo_full  = (count_q == DepthCr);
    assign fifo_empty = (count_q == '0);
    assign fifo_wr    = cap_valid & ~fifo_full;
    assign overflow   = cap_valid & fifo_full;

    assign resp_valid = rst & ~fifo_empty;
    assign resp_id    = mem_id_q[rd_ptr_q];
    assign resp_data  = mem_data_q[rd_ptr_q];
    assign pop        = resp_valid & resp_ready;

    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            mem_data_q[wr_ptr_q] <= pipe_out;
            mem_id_q[wr_ptr_q]   <= cap_id;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (fifo_wr) begin
            wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
        end
        if (fifo_wr && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!fifo_wr && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Credits and tracking error
    // ------------------------------------------------------------------
    always_comb begin
        credits_d = credits_q;
        if (issue && !pop) begin
            credits_d = credits_q - 1'b1;
        end else if (!issue && pop) begin
            credits_d = credits_q + 1'b1;
        end
    end

    always_comb begin
        track_err_d = track_err_q;
        if ((pipe_output_valid != cap_valid) || overflow) begin
            track_err_d = 1'b1;
        end
    end

    assign credits   = credits_q;
    assign track_err = track_err_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr_q    <= '0;
            credits_q   <= DepthCr;
            track_err_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            credits_q   <= credits_d;
            track_err_q <= track_err_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

endmodule

// File: tb/tb_pipe_share_sched.sv
// Testbench for pipe_share_sched: a behavioural stand-in for the shared pipeline, directed
// scenarios and randomized traffic, all checked against a queue-based transaction model.
module tb_pipe_share_sched;

    localparam int N = 4;
    localparam int L = 2;
    localparam int W = 32;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] req_valid = '0;
    logic [N-1:0] req_ready;
    logic         pipe_rst;
    logic         pipe_input_valid;
    logic         pipe_output_valid;
    logic [W-1:0] pipe_out;
    logic         resp_valid;
    logic [1:0]   resp_id;
    logic [W-1:0] resp_data;
    logic         resp_ready = 1'b0;
    logic [2:0]   credits;
    logic         track_err;

    always #5 clk = ~clk;

    pipe_share_sched #(
        .NUM_REQ   (N),
        .LATENCY   (L),
        .DATA_W    (W),
        .FIFO_DEPTH(D)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .pipe_rst         (pipe_rst),
        .pipe_input_valid (pipe_input_valid),
        .pipe_output_valid(pipe_output_valid),
        .pipe_out         (pipe_out),
        .resp_valid       (resp_valid),
        .resp_id          (resp_id),
        .resp_data        (resp_data),
        .resp_ready       (resp_ready),
        .credits          (credits),
        .track_err        (track_err)
    );

    // Stand-in for the shared pipeline: valid and data delayed L cycles, cleared by pipe_rst.
    logic [W-1:0] pipe_in_data = '0;
    logic         inject = 1'b0;
    logic [L-1:0] pv = '0;
    logic [W-1:0] pd [L];

    always @(posedge clk) begin
        if (pipe_rst) begin
            pv <= '0;
        end else begin
            pv[0] <= pipe_input_valid;
            for (int s = 1; s < L; s++) pv[s] <= pv[s-1];
        end
        pd[0] <= pipe_in_data;
        for (int s = 1; s < L; s++) pd[s] <= pd[s-1];
    end

    assign pipe_output_valid = pv[L-1] | inject;
    assign pipe_out          = pd[L-1];

    // Transaction-level reference model.
    typedef struct {
        int           id;
        logic [W-1:0] data;
        int           rem;
    } item_t;

    item_t flight[$];
    item_t fifo_m[$];
    int    rr_m;
    bit    err_m;
    int    checks;
    int    errors;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One cycle: drive at negedge, compare against the model, advance the model over the edge.
    task automatic step(input logic [N-1:0] rv, input bit rdy, input bit rs, input bit inj);
        int           gid;
        int           exp_cr;
        logic [N-1:0] exp_gnt;
        bit           due;
        item_t        it;
        req_valid    = rv;
        resp_ready   = rdy;
        rst          = rs;
        inject       = inj;
        pipe_in_data = $urandom;
        #1;
        gid     = -1;
        exp_gnt = '0;
        exp_cr  = D - flight.size() - fifo_m.size();
        if (rs && exp_cr > 0) begin
            for (int i = 0; i < N; i++) begin
                int k;
                k = (rr_m + i) % N;
                if (gid < 0 && rv[k]) gid = k;
            end
        end
        if (gid >= 0) exp_gnt[gid] = 1'b1;
        check("req_ready", 64'(req_ready), 64'(exp_gnt));
        check("pipe_input_valid", 64'(pipe_input_valid), 64'(gid >= 0));
        check("pipe_rst", 64'(pipe_rst), 64'(!rs));
        check("credits", 64'(credits), 64'(exp_cr));
        check("resp_valid", 64'(resp_valid), 64'(rs && fifo_m.size() > 0));
        if (rs && fifo_m.size() > 0) begin
            check("resp_id", 64'(resp_id), 64'(fifo_m[0].id));
            check("resp_data", 64'(resp_data), 64'(fifo_m[0].data));
        end
        check("track_err", 64'(track_err), 64'(err_m));

        if (!rs) begin
            flight.delete();
            fifo_m.delete();
            rr_m  = 0;
            err_m = 1'b0;
        end else begin
            if (rdy && fifo_m.size() > 0) void'(fifo_m.pop_front());
            due = (flight.size() > 0) && (flight[0].rem == 1);
            if (inj && !due) err_m = 1'b1;
            for (int i = 0; i < flight.size(); i++) flight[i].rem--;
            while (flight.size() > 0 && flight[0].rem == 0) fifo_m.push_back(flight.pop_front());
            if (gid >= 0) begin
                it.id   = gid;
                it.data = pipe_in_data;
                it.rem  = L;
                flight.push_back(it);
                rr_m = (gid + 1) % N;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        repeat (8) step('0, 1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rr_m   = 0;
        err_m  = 1'b0;
        rst    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);

        // Reset state, then a single request.
        step('0, 1'b1, 1'b1, 1'b0);
        step(4'b0001, 1'b1, 1'b1, 1'b0);
        repeat (5) step('0, 1'b1, 1'b1, 1'b0);

        // Round robin with all requesters active.
        repeat (8) step(4'b1111, 1'b1, 1'b1, 1'b0);
        drain();

        // Credit stall, then a single pop and a simultaneous issue/pop.
        repeat (8) step(4'b0010, 1'b0, 1'b1, 1'b0);
        check("stall_credits", 64'(credits), 64'd0);
        check("stall_head_id", 64'(resp_id), 64'd1);
        step(4'b0010, 1'b1, 1'b1, 1'b0);
        check("pop_credits", 64'(credits), 64'd1);
        step(4'b0010, 1'b1, 1'b1, 1'b0);
        check("issue_pop_credits", 64'(credits), 64'd1);
        drain();

        // Reset with two transactions in flight.
        repeat (2) step(4'b1111, 1'b1, 1'b1, 1'b0);
        step('0, 1'b1, 1'b0, 1'b0);
        repeat (6) step('0, 1'b1, 1'b1, 1'b0);
        check("post_reset_credits", 64'(credits), 64'd4);

        // Spurious pipeline valid with the shadow pipe empty.
        drain();
        step('0, 1'b1, 1'b1, 1'b1);
        check("inject_err", 64'(track_err), 64'd1);
        repeat (3) step(4'b0100, 1'b1, 1'b1, 1'b0);
        step('0, 1'b1, 1'b0, 1'b0);
        step('0, 1'b1, 1'b1, 1'b0);
        check("err_cleared", 64'(track_err), 64'd0);

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 2000; c++) begin
            step(N'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 63) != 0), 1'b0);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
